// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle for muldiv_unit.
//   Request side : flush, in_valid/in_ready, func3, a, b, tag_in
//   Response side: out_valid/out_ready, result, tag_out
// master = issuing stage (execute pipeline), slave = muldiv_unit.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       func3;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output flush, in_valid, func3, a, b, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out
  );

  modport slave (
    input  flush, in_valid, func3, a, b, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential RV32M/RV64M multiply/divide unit.
// Multiplies are shift-add over operand magnitudes, divides are restoring
// radix-2; both take XLEN iteration cycles plus one sign-fix cycle.
// Divide-by-zero and signed overflow (and all multiplies when FAST_MUL=1)
// complete on the accept edge.
// Ports:
//   clk - clock, rst - synchronous active-high reset
//   bus - muldiv_if slave: flush, in_valid/in_ready, func3, a, b, tag_in,
//         out_valid/out_ready, result, tag_out
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int FAST_MUL = 0
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic en);
    return en ? ('0 - x) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] x, input logic en);
    return en ? ('0 - x) : x;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;     // product high half / partial remainder
  logic [XLEN-1:0]  lo_q, lo_d;     // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0]  opnd_q, opnd_d; // multiplicand or divisor magnitude
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;   // negate product or quotient in FIX
  logic             negr_q, negr_d; // negate remainder in FIX
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [TAG_W-1:0] tago_q, tago_d;

  logic                   is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, take_fast;
  logic [XLEN-1:0]        a_mag, b_mag, fast_res, fix_res, quo, rem;
  logic [XLEN:0]          sum, shifted, diff;
  logic [2*XLEN-1:0]      prod_f;
  logic signed [2*XLEN-1:0] fa, fb, fprod;

  always_comb begin
    // Request decode (only meaningful while IDLE)
    is_div = bus.func3[2];
    a_sgn  = is_div ? ~bus.func3[0] : (bus.func3[1:0] == 2'b01 || bus.func3[1:0] == 2'b10);
    b_sgn  = is_div ? ~bus.func3[0] : (bus.func3[1:0] == 2'b01);
    a_neg  = a_sgn & bus.a[XLEN-1];
    b_neg  = b_sgn & bus.b[XLEN-1];
    a_mag  = cond_neg(bus.a, a_neg);
    b_mag  = cond_neg(bus.b, b_neg);
    b_zero = (bus.b == '0);
    ovf    = ~bus.func3[0] && (bus.a == INT_MIN) && (bus.b == '1);

    // Sign-extending to 2*XLEN makes the truncated product correct for
    // every signed/unsigned operand mix.
    fa    = {{XLEN{a_neg}}, bus.a};
    fb    = {{XLEN{b_neg}}, bus.b};
    fprod = fa * fb;

    if (is_div && b_zero)      fast_res = bus.func3[1] ? bus.a : '1;
    else if (is_div && ovf)    fast_res = bus.func3[1] ? '0 : bus.a;
    else if (bus.func3 == 3'b000) fast_res = fprod[XLEN-1:0];
    else                       fast_res = fprod[2*XLEN-1:XLEN];
    take_fast = is_div ? (b_zero | ovf) : (FAST_MUL != 0);

    // One shift-add step
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // One restoring-divide step; diff[XLEN] set means the trial subtract failed
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opnd_q};

    // Sign correction and half select
    prod_f = cond_neg2({hi_q, lo_q}, neg_q);
    quo    = cond_neg(lo_q, neg_q);
    rem    = cond_neg(hi_q, negr_q);
    if (op_q[2])              fix_res = op_q[1] ? rem : quo;
    else if (op_q == 3'b000)  fix_res = prod_f[XLEN-1:0];
    else                      fix_res = prod_f[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    tag_d   = tag_q;
    res_d   = res_q;
    tago_d  = tago_q;

    if (bus.flush) begin
      // Abort wins over accept and over the result handshake
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_d  = bus.func3;
            tag_d = bus.tag_in;
            if (take_fast) begin
              res_d   = fast_res;
              tago_d  = bus.tag_in;
              state_d = DONE;
            end else begin
              hi_d    = '0;
              lo_d    = is_div ? a_mag : b_mag;
              opnd_d  = is_div ? b_mag : a_mag;
              neg_d   = a_neg ^ b_neg;
              negr_d  = a_neg;
              cnt_d   = '0;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            if (diff[XLEN]) begin
              hi_d = shifted[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end else begin
              hi_d = diff[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end
          end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = FIX;
        end
        FIX: begin
          res_d   = fix_res;
          tago_d  = tag_q;
          state_d = DONE;
        end
        default: begin
          if (bus.out_ready) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      tago_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      tago_q  <= tago_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.tag_out   = tago_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit. Index 0 is the iterative
// unit (FAST_MUL=0), index 1 the fast-multiply unit (FAST_MUL=1).
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32), .TAG_W(5)) sbus ();
  muldiv_if #(.XLEN(32), .TAG_W(5)) fbus ();

  muldiv_unit #(.XLEN(32), .TAG_W(5), .FAST_MUL(0)) u_slow (.clk(clk), .rst(rst), .bus(sbus));
  muldiv_unit #(.XLEN(32), .TAG_W(5), .FAST_MUL(1)) u_fast (.clk(clk), .rst(rst), .bus(fbus));

  logic        fl_r[2], iv_r[2], or_r[2];
  logic [2:0]  f3_r[2];
  logic [31:0] a_r[2], b_r[2];
  logic [4:0]  tg_r[2];
  logic        ov_w[2], ir_w[2];
  logic [31:0] res_w[2];
  logic [4:0]  tago_w[2];

  assign sbus.flush = fl_r[0];  assign fbus.flush = fl_r[1];
  assign sbus.in_valid = iv_r[0];  assign fbus.in_valid = iv_r[1];
  assign sbus.out_ready = or_r[0]; assign fbus.out_ready = or_r[1];
  assign sbus.func3 = f3_r[0];  assign fbus.func3 = f3_r[1];
  assign sbus.a = a_r[0];  assign fbus.a = a_r[1];
  assign sbus.b = b_r[0];  assign fbus.b = b_r[1];
  assign sbus.tag_in = tg_r[0];  assign fbus.tag_in = tg_r[1];
  assign ov_w[0] = sbus.out_valid;  assign ov_w[1] = fbus.out_valid;
  assign ir_w[0] = sbus.in_ready;   assign ir_w[1] = fbus.in_ready;
  assign res_w[0] = sbus.result;    assign res_w[1] = fbus.result;
  assign tago_w[0] = sbus.tag_out;  assign tago_w[1] = fbus.tag_out;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Present one request in the current cycle (C0); returns in C1.
  task automatic start_op(input int u, input logic [2:0] f3, input logic [31:0] av,
                          input logic [31:0] bv, input logic [4:0] tg);
    f3_r[u] = f3; a_r[u] = av; b_r[u] = bv; tg_r[u] = tg; iv_r[u] = 1'b1;
    @(posedge clk); #1;
    iv_r[u] = 1'b0;
  endtask

  task automatic run_op(input int u, input string nm, input logic [2:0] f3,
                        input logic [31:0] av, input logic [31:0] bv, input logic [4:0] tg,
                        input int exp_lat, input logic [31:0] exp_res);
    int   lat;
    logic ir_bad;
    or_r[u] = 1'b1;
    start_op(u, f3, av, bv, tg);
    lat = 1;
    ir_bad = 1'b0;
    while (!ov_w[u] && lat < 100) begin
      if (ir_w[u]) ir_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_res"}, res_w[u], exp_res);
    chk({nm, "_tag"}, tago_w[u], tg);
    chk({nm, "_busy"}, {ir_bad, ir_w[u]}, 2'b00);
    @(posedge clk); #1;
    chk({nm, "_ret"}, {ov_w[u], ir_w[u]}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 2; i++) begin
      fl_r[i] = 0; iv_r[i] = 0; or_r[i] = 1; f3_r[i] = 0; a_r[i] = 0; b_r[i] = 0; tg_r[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", {ir_w[0], ov_w[0], res_w[0], 3'b000, tago_w[0]}, {2'b10, 32'h0, 8'h00});

    // Iterative multiplies
    run_op(0, "mul",    3'b000, 32'd12,        32'd5,         5'd3, 34, 32'd60);
    run_op(0, "mul_lo", 3'b000, 32'hFFFFFFFF,  32'd3,         5'd4, 34, 32'hFFFFFFFD);
    run_op(0, "mulh",   3'b001, 32'h80000000,  32'h80000000,  5'd5, 34, 32'h40000000);
    run_op(0, "mulhu",  3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd6, 34, 32'hFFFFFFFE);
    run_op(0, "mulhsu", 3'b010, 32'hFFFFFFFF,  32'd2,         5'd7, 34, 32'hFFFFFFFF);

    // Fast multiplies
    run_op(1, "f_mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd8, 1, 32'h40000000);
    run_op(1, "f_mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1, 32'hFFFFFFFE);
    run_op(1, "f_mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd10, 1, 32'hFFFFFFFF);
    run_op(1, "f_mul",    3'b000, 32'hFFFFFFFD, 32'd5,        5'd11, 1, 32'hFFFFFFF1);

    // Divides
    run_op(0, "div_neg",  3'b100, 32'hFFFFFFF4, 32'd3,        5'd12, 34, 32'hFFFFFFFC);
    run_op(0, "divu",     3'b101, 32'd12,       32'd3,        5'd13, 34, 32'd4);
    run_op(0, "rem_neg",  3'b110, 32'hFFFFFFF3, 32'd3,        5'd14, 34, 32'hFFFFFFFF);
    run_op(0, "remu",     3'b111, 32'd13,       32'd3,        5'd15, 34, 32'd1);
    run_op(0, "div_nb",   3'b100, 32'd7,        32'hFFFFFFFE, 5'd16, 34, 32'hFFFFFFFD);
    run_op(0, "rem_nb",   3'b110, 32'd7,        32'hFFFFFFFE, 5'd17, 34, 32'd1);

    // Special cases
    run_op(0, "div_z",    3'b100, 32'd7,        32'd0,        5'd18, 1, 32'hFFFFFFFF);
    run_op(0, "remu_z",   3'b111, 32'd7,        32'd0,        5'd19, 1, 32'd7);
    run_op(0, "div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd20, 1, 32'h80000000);
    run_op(0, "rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd21, 1, 32'd0);

    // Backpressure
    or_r[0] = 1'b0;
    start_op(0, 3'b101, 32'd100, 32'd7, 5'd9);
    lat = 1;
    while (!ov_w[0] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", lat, 34);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {ov_w[0], ir_w[0], res_w[0], 3'b000, tago_w[0]}, {2'b10, 32'd14, 8'd9});
      @(posedge clk); #1;
    end
    chk("bp_last", {ov_w[0], res_w[0]}, {1'b1, 32'd14});
    or_r[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {ov_w[0], ir_w[0]}, 2'b01);

    // Flush in IDLE beats a fast-path accept
    fl_r[0] = 1'b1;
    f3_r[0] = 3'b100; a_r[0] = 32'd7; b_r[0] = 32'd0; tg_r[0] = 5'd2; iv_r[0] = 1'b1;
    @(posedge clk); #1;
    fl_r[0] = 1'b0; iv_r[0] = 1'b0;
    chk("flush_noacc", {ov_w[0], ir_w[0], res_w[0]}, {2'b01, 32'd14});

    // Flush mid-divide at C10
    start_op(0, 3'b100, 32'd100, 32'd3, 5'd22);
    repeat (9) @(posedge clk);
    #1 fl_r[0] = 1'b1;
    @(posedge clk); #1;
    fl_r[0] = 1'b0;
    chk("flush_idle", {ov_w[0], ir_w[0]}, 2'b01);
    run_op(0, "post_flush_mul", 3'b000, 32'd3, 32'd4, 5'd23, 34, 32'd12);

    // Reset mid-CALC
    start_op(0, 3'b100, 32'd100, 32'd3, 5'd24);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid", {ir_w[0], ov_w[0], res_w[0], 3'b000, tago_w[0]}, {2'b10, 32'h0, 8'h00});
    rst = 1'b0;
    run_op(0, "post_rst_divu", 3'b101, 32'd100, 32'd7, 5'd25, 34, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
